// File: rtl/btb_write_arbiter_if.sv
// btb_write_arbiter_if
//   Bundles the request side (STALL, invalidate, ID allocations, IF touches) and the
//   single BTB array write port of the BTB write arbiter.
//   master : pipeline/array side; drives requests and observes the write port
//   slave  : the arbiter; consumes requests and drives the write port
interface btb_write_arbiter_if #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned TAG_W      = 21
);
  logic                  STALL;
  logic                  inv_req_IN;
  logic                  alloc_valid_IN;
  logic [DEPTH_LOG2-1:0] alloc_index_IN;
  logic [TAG_W-1:0]      alloc_tag_IN;
  logic [31:0]           alloc_target_IN;
  logic                  alloc_ready_OUT;
  logic                  touch_valid_IN;
  logic [DEPTH_LOG2-1:0] touch_index_IN;
  logic                  touch_way_IN;
  logic                  wr_en_OUT;
  logic [1:0]            wr_kind_OUT;
  logic [DEPTH_LOG2-1:0] wr_index_OUT;
  logic [TAG_W-1:0]      wr_tag_OUT;
  logic [31:0]           wr_target_OUT;
  logic                  wr_way_OUT;
  logic                  busy_OUT;
  logic                  touch_drop_OUT;

  modport master (
    output STALL, inv_req_IN,
    output alloc_valid_IN, alloc_index_IN, alloc_tag_IN, alloc_target_IN,
    input  alloc_ready_OUT,
    output touch_valid_IN, touch_index_IN, touch_way_IN,
    input  wr_en_OUT, wr_kind_OUT, wr_index_OUT, wr_tag_OUT, wr_target_OUT, wr_way_OUT,
    input  busy_OUT, touch_drop_OUT
  );

  modport slave (
    input  STALL, inv_req_IN,
    input  alloc_valid_IN, alloc_index_IN, alloc_tag_IN, alloc_target_IN,
    output alloc_ready_OUT,
    input  touch_valid_IN, touch_index_IN, touch_way_IN,
    output wr_en_OUT, wr_kind_OUT, wr_index_OUT, wr_tag_OUT, wr_target_OUT, wr_way_OUT,
    output busy_OUT, touch_drop_OUT
  );
endinterface

// File: rtl/btb_write_arbiter.sv
// btb_write_arbiter
//   Single write-port arbiter/sequencer for the 2-way, 2^DEPTH_LOG2-set BTB array.
//   Requesters: invalidation sweep (after reset or inv_req_IN), ID allocations (buffered
//   in a FIFO_DEPTH-entry FIFO with duplicate suppression) and IF LRU touches (never
//   queued; dropped with a touch_drop_OUT pulse when they cannot be issued).
// Ports
//   CLK    : clock, rising edge
//   RESET  : asynchronous, active-low reset
//   bus    : btb_write_arbiter_if.slave (requests in, registered write port out)
// Optional feature (macro BTB_ARB_STATS_EN)
//   Adds stat_touch_drops_OUT / stat_alloc_drops_OUT, saturating 16-bit drop counters.
module btb_write_arbiter #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned TAG_W      = 21,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  btb_write_arbiter_if.slave        bus
`ifdef BTB_ARB_STATS_EN
  ,
  output logic [15:0]               stat_touch_drops_OUT,
  output logic [15:0]               stat_alloc_drops_OUT
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [DEPTH_LOG2-1:0] LastIdx = '1;

  localparam logic [1:0] KindNone  = 2'b00;
  localparam logic [1:0] KindAlloc = 2'b01;
  localparam logic [1:0] KindTouch = 2'b10;
  localparam logic [1:0] KindInv   = 2'b11;

  typedef enum logic [0:0] {StSweep, StIdle} state_e;

  typedef struct packed {
    logic [DEPTH_LOG2-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic [31:0]           target;
  } alloc_t;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  alloc_t                fifo_q [FIFO_DEPTH];
  alloc_t                fifo_d [FIFO_DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  wr_en_q, wr_en_d;
  logic [1:0]            wr_kind_q, wr_kind_d;
  logic [DEPTH_LOG2-1:0] wr_index_q, wr_index_d;
  logic [TAG_W-1:0]      wr_tag_q, wr_tag_d;
  logic [31:0]           wr_target_q, wr_target_d;
  logic                  wr_way_q, wr_way_d;
  logic                  busy_q, busy_d;
  logic                  touch_drop_q, touch_drop_d;

  alloc_t                in_alloc;
  logic                  ready, accept, dup;
  logic [PtrW-1:0]       off [FIFO_DEPTH];
  logic [DEPTH_LOG2-1:0] sweep_idx;
  logic                  alloc_issued, bypass, push, pop;

  assign in_alloc = '{index: bus.alloc_index_IN, tag: bus.alloc_tag_IN,
                      target: bus.alloc_target_IN};
  // A same-cycle pop does not free a slot: ready looks only at the current count.
  assign ready    = (state_q == StIdle) && (count_q != CntW'(FIFO_DEPTH));
  assign accept   = bus.alloc_valid_IN && ready;

  // Duplicate if it matches any live FIFO slot or the alloc write now on the port.
  always_comb begin
    dup = 1'b0;
    for (int unsigned s = 0; s < FIFO_DEPTH; s++) begin
      off[s] = PtrW'(s) - rd_ptr_q;
      if (({1'b0, off[s]} < count_q) && (fifo_q[s].index == in_alloc.index) &&
          (fifo_q[s].tag == in_alloc.tag)) begin
        dup = 1'b1;
      end
    end
    if (wr_en_q && (wr_kind_q == KindAlloc) && (wr_index_q == in_alloc.index) &&
        (wr_tag_q == in_alloc.tag)) begin
      dup = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    wr_en_d      = 1'b0;
    wr_kind_d    = KindNone;
    wr_index_d   = '0;
    wr_tag_d     = '0;
    wr_target_d  = '0;
    wr_way_d     = 1'b0;
    busy_d       = 1'b0;
    touch_drop_d = 1'b0;
    sweep_idx    = '0;
    alloc_issued = 1'b0;
    bypass       = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;

    if (bus.inv_req_IN || (state_q == StSweep)) begin
      // A new request restarts the sweep from set 0; STALL is ignored here.
      sweep_idx    = bus.inv_req_IN ? '0 : cnt_q;
      wr_en_d      = 1'b1;
      wr_kind_d    = KindInv;
      wr_index_d   = sweep_idx;
      busy_d       = 1'b1;
      cnt_d        = sweep_idx + 1'b1;
      state_d      = (sweep_idx == LastIdx) ? StIdle : StSweep;
      touch_drop_d = bus.touch_valid_IN;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
    end else begin
      if (!bus.STALL) begin
        if (count_q != '0) begin
          pop          = 1'b1;
          alloc_issued = 1'b1;
          wr_en_d      = 1'b1;
          wr_kind_d    = KindAlloc;
          wr_index_d   = fifo_q[rd_ptr_q].index;
          wr_tag_d     = fifo_q[rd_ptr_q].tag;
          wr_target_d  = fifo_q[rd_ptr_q].target;
        end else if (accept && !dup) begin
          bypass       = 1'b1;
          alloc_issued = 1'b1;
          wr_en_d      = 1'b1;
          wr_kind_d    = KindAlloc;
          wr_index_d   = in_alloc.index;
          wr_tag_d     = in_alloc.tag;
          wr_target_d  = in_alloc.target;
        end else if (bus.touch_valid_IN) begin
          wr_en_d      = 1'b1;
          wr_kind_d    = KindTouch;
          wr_index_d   = bus.touch_index_IN;
          wr_way_d     = bus.touch_way_IN;
        end
      end
      touch_drop_d = bus.touch_valid_IN && (bus.STALL || alloc_issued);
      push         = accept && !dup && !bypass;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
        fifo_d[wr_ptr_q] = in_alloc;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

`ifdef BTB_ARB_STATS_EN
  logic [15:0] stat_touch_q, stat_touch_d, stat_alloc_q, stat_alloc_d;

  // Duplicates count as accepted, so only not-ready discards bump the alloc counter.
  always_comb begin
    stat_touch_d = stat_touch_q;
    stat_alloc_d = stat_alloc_q;
    if (touch_drop_d && (stat_touch_q != 16'hFFFF)) begin
      stat_touch_d = stat_touch_q + 16'd1;
    end
    if (bus.alloc_valid_IN && !ready && (stat_alloc_q != 16'hFFFF)) begin
      stat_alloc_d = stat_alloc_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stat_touch_q <= '0;
      stat_alloc_q <= '0;
    end else begin
      stat_touch_q <= stat_touch_d;
      stat_alloc_q <= stat_alloc_d;
    end
  end

  assign stat_touch_drops_OUT = stat_touch_q;
  assign stat_alloc_drops_OUT = stat_alloc_q;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StSweep;
      cnt_q        <= '0;
      fifo_q       <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_kind_q    <= KindNone;
      wr_index_q   <= '0;
      wr_tag_q     <= '0;
      wr_target_q  <= '0;
      wr_way_q     <= 1'b0;
      busy_q       <= 1'b1;
      touch_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      wr_en_q      <= wr_en_d;
      wr_kind_q    <= wr_kind_d;
      wr_index_q   <= wr_index_d;
      wr_tag_q     <= wr_tag_d;
      wr_target_q  <= wr_target_d;
      wr_way_q     <= wr_way_d;
      busy_q       <= busy_d;
      touch_drop_q <= touch_drop_d;
    end
  end

  assign bus.alloc_ready_OUT = ready;
  assign bus.wr_en_OUT       = wr_en_q;
  assign bus.wr_kind_OUT     = wr_kind_q;
  assign bus.wr_index_OUT    = wr_index_q;
  assign bus.wr_tag_OUT      = wr_tag_q;
  assign bus.wr_target_OUT   = wr_target_q;
  assign bus.wr_way_OUT      = wr_way_q;
  assign bus.busy_OUT        = busy_q;
  assign bus.touch_drop_OUT  = touch_drop_q;

endmodule

// File: tb/tb_btb_write_arbiter.sv
// tb_btb_write_arbiter
//   Self-checking bench for btb_write_arbiter: directed scenarios plus randomized traffic
//   compared against a queue-based reference model. Stats checks only when
//   BTB_ARB_STATS_EN is defined.
module tb_btb_write_arbiter;

  localparam logic [67:0] RST_VEC = 68'h2;  // everything 0 except busy_OUT

  logic clk = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  btb_write_arbiter_if #(.DEPTH_LOG2(9), .TAG_W(21)) bus ();

`ifdef BTB_ARB_STATS_EN
  logic [15:0] stat_touch, stat_alloc;
  btb_write_arbiter #(.DEPTH_LOG2(9), .TAG_W(21), .FIFO_DEPTH(4)) dut (
    .CLK(clk), .RESET(RESET), .bus(bus),
    .stat_touch_drops_OUT(stat_touch), .stat_alloc_drops_OUT(stat_alloc)
  );
`else
  btb_write_arbiter #(.DEPTH_LOG2(9), .TAG_W(21), .FIFO_DEPTH(4)) dut (
    .CLK(clk), .RESET(RESET), .bus(bus)
  );
`endif

  logic [67:0] obs;
  assign obs = {bus.wr_en_OUT, bus.wr_kind_OUT, bus.wr_index_OUT, bus.wr_tag_OUT,
                bus.wr_target_OUT, bus.wr_way_OUT, bus.busy_OUT, bus.touch_drop_OUT};

  // ---------------- reference model ----------------
  typedef struct {
    logic [8:0]  idx;
    logic [20:0] tag;
    logic [31:0] tgt;
  } ent_t;

  ent_t        m_q[$];
  bit          m_sweep;
  int          m_cnt;
  int          m_touch_drops, m_alloc_drops;
  logic        e_en, e_way, e_busy, e_drop;
  logic [1:0]  e_kind;
  logic [8:0]  e_idx;
  logic [20:0] e_tag;
  logic [31:0] e_tgt;

  function automatic logic [67:0] exp_vec();
    return {e_en, e_kind, e_idx, e_tag, e_tgt, e_way, e_busy, e_drop};
  endfunction

  function automatic bit exp_ready();
    return !m_sweep && (m_q.size() < 4);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_sweep = 1'b1;
    m_cnt   = 0;
    m_touch_drops = 0;
    m_alloc_drops = 0;
    {e_en, e_kind, e_idx, e_tag, e_tgt, e_way, e_drop} = '0;
    e_busy = 1'b1;
  endtask

  // One clock edge worth of behaviour, from the current inputs.
  task automatic model_edge();
    bit   rdy, dup, issued, byp;
    ent_t in_e;
    in_e.idx = bus.alloc_index_IN;
    in_e.tag = bus.alloc_tag_IN;
    in_e.tgt = bus.alloc_target_IN;
    rdy = exp_ready();
    dup = 1'b0;
    if (bus.alloc_valid_IN && rdy) begin
      foreach (m_q[k]) if (m_q[k].idx == in_e.idx && m_q[k].tag == in_e.tag) dup = 1'b1;
      if (e_en && e_kind == 2'b01 && e_idx == in_e.idx && e_tag == in_e.tag) dup = 1'b1;
    end
    if (bus.alloc_valid_IN && !rdy && m_alloc_drops < 65535) m_alloc_drops++;
    {e_en, e_kind, e_idx, e_tag, e_tgt, e_way, e_busy, e_drop} = '0;
    if (bus.inv_req_IN || m_sweep) begin
      if (bus.inv_req_IN) m_cnt = 0;
      e_en   = 1'b1;
      e_kind = 2'b11;
      e_idx  = 9'(m_cnt);
      e_busy = 1'b1;
      m_cnt++;
      m_sweep = (m_cnt < 512);
      m_q.delete();
      e_drop = bus.touch_valid_IN;
    end else begin
      issued = 1'b0;
      byp    = 1'b0;
      if (!bus.STALL) begin
        if (m_q.size() > 0) begin
          ent_t h;
          h = m_q.pop_front();
          {e_en, e_kind, e_idx, e_tag, e_tgt} = {1'b1, 2'b01, h.idx, h.tag, h.tgt};
          issued = 1'b1;
        end else if (bus.alloc_valid_IN && !dup) begin
          {e_en, e_kind, e_idx, e_tag, e_tgt} = {1'b1, 2'b01, in_e.idx, in_e.tag, in_e.tgt};
          issued = 1'b1;
          byp    = 1'b1;
        end else if (bus.touch_valid_IN) begin
          {e_en, e_kind, e_idx, e_way} = {1'b1, 2'b10, bus.touch_index_IN, bus.touch_way_IN};
        end
      end
      e_drop = bus.touch_valid_IN && (bus.STALL || issued);
      if (bus.alloc_valid_IN && rdy && !dup && !byp) m_q.push_back(in_e);
    end
    if (e_drop && m_touch_drops < 65535) m_touch_drops++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.STALL = 1'b0;
    bus.inv_req_IN = 1'b0;
    bus.alloc_valid_IN = 1'b0;
    bus.alloc_index_IN = '0;
    bus.alloc_tag_IN = '0;
    bus.alloc_target_IN = '0;
    bus.touch_valid_IN = 1'b0;
    bus.touch_index_IN = '0;
    bus.touch_way_IN = 1'b0;
  endtask

  task automatic set_alloc(input logic [8:0] idx, input logic [20:0] tag, input logic [31:0] tgt);
    bus.alloc_valid_IN  = 1'b1;
    bus.alloc_index_IN  = idx;
    bus.alloc_tag_IN    = tag;
    bus.alloc_target_IN = tgt;
  endtask

  // Runs out a sweep with inputs idle; used only to get back to IDLE.
  task automatic wait_idle();
    for (int k = 0; k < 600 && m_sweep; k++) step();
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    if (obs !== RST_VEC) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, RST_VEC);
    end
    n_checks++;
    if (bus.alloc_ready_OUT !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", bus.alloc_ready_OUT);
    end
    n_checks++;
`ifdef BTB_ARB_STATS_EN
    if ({stat_touch, stat_alloc} !== 32'h0) begin
      n_fail++; $display("FAIL reset_stats: got %h want 0", {stat_touch, stat_alloc});
    end
    n_checks++;
`endif
  endtask

  task automatic test_sweep();
    RESET = 1'b1;
    for (int i = 0; i < 512; i++) begin
      bus.touch_valid_IN = (i == 100);
      bus.touch_index_IN = 9'h033;
      step();
      if (bus.wr_en_OUT !== 1'b1 || bus.wr_kind_OUT !== 2'b11 || bus.wr_index_OUT !== 9'(i) ||
          bus.busy_OUT !== 1'b1 || bus.touch_drop_OUT !== 1'(i == 100) || obs !== exp_vec()) begin
        n_fail++; $display("FAIL sweep[%0d]: got %h want %h", i, obs, exp_vec());
      end
      n_checks++;
    end
    bus.touch_valid_IN = 1'b0;
    step();
    if (bus.busy_OUT !== 1'b0 || bus.wr_en_OUT !== 1'b0) begin
      n_fail++; $display("FAIL sweep_end: got busy=%b en=%b want 0 0", bus.busy_OUT, bus.wr_en_OUT);
    end
    n_checks++;
    if (bus.alloc_ready_OUT !== 1'b1) begin
      n_fail++; $display("FAIL sweep_ready: got %b want 1", bus.alloc_ready_OUT);
    end
    n_checks++;
  endtask

  task automatic test_bypass();
    set_alloc(9'h1A3, 21'h0ABCD, 32'h0040_0120);
    step();
    bus.alloc_valid_IN = 1'b0;
    if ({bus.wr_en_OUT, bus.wr_kind_OUT, bus.wr_index_OUT, bus.wr_tag_OUT, bus.wr_target_OUT}
        !== {1'b1, 2'b01, 9'h1A3, 21'h0ABCD, 32'h0040_0120} || obs !== exp_vec()) begin
      n_fail++; $display("FAIL bypass: got %h want %h", obs, exp_vec());
    end
    n_checks++;
  endtask

  task automatic test_stall_fill();
    bus.STALL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_alloc(9'(256 + i), 21'(i + 7), 32'(32'h1000 + i * 4));
      if (bus.alloc_ready_OUT !== 1'(i < 4)) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got %b want %b", i, bus.alloc_ready_OUT, i < 4);
      end
      n_checks++;
      step();
      if (bus.wr_en_OUT !== 1'b0) begin
        n_fail++; $display("FAIL stall_no_write[%0d]: got %b want 0", i, bus.wr_en_OUT);
      end
      n_checks++;
    end
    bus.alloc_valid_IN = 1'b0;
    step();
    bus.STALL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if ({bus.wr_en_OUT, bus.wr_kind_OUT, bus.wr_index_OUT, bus.wr_tag_OUT} !==
          {1'b1, 2'b01, 9'(256 + i), 21'(i + 7)} || obs !== exp_vec()) begin
        n_fail++; $display("FAIL drain[%0d]: got %h want %h", i, obs, exp_vec());
      end
      n_checks++;
    end
    step();
    if (bus.wr_en_OUT !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got %b want 0", bus.wr_en_OUT);
    end
    n_checks++;
  endtask

  task automatic test_touch();
    set_alloc(9'h0AA, 21'h5, 32'h200);
    bus.touch_valid_IN = 1'b1;
    bus.touch_index_IN = 9'h010;
    bus.touch_way_IN   = 1'b1;
    step();
    bus.alloc_valid_IN = 1'b0;
    if (bus.wr_kind_OUT !== 2'b01 || bus.wr_index_OUT !== 9'h0AA || bus.touch_drop_OUT !== 1'b1) begin
      n_fail++; $display("FAIL touch_lose: got %h want alloc+drop", obs);
    end
    n_checks++;
    step();
    bus.touch_valid_IN = 1'b0;
    if (obs !== {1'b1, 2'b10, 9'h010, 21'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL touch_win: got %h want kind10 idx010 way1", obs);
    end
    n_checks++;
  endtask

  task automatic test_dup();
    int writes = 0;
    int drops_before;
    drops_before = m_alloc_drops;
    bus.STALL = 1'b1;
    set_alloc(9'h055, 21'h1, 32'h3000);
    step();
    step();
    bus.alloc_valid_IN = 1'b0;
    bus.STALL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.wr_en_OUT === 1'b1 && bus.wr_kind_OUT === 2'b01 && bus.wr_index_OUT === 9'h055)
        writes++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL dup_cycle[%0d]: got %h want %h", i, obs, exp_vec());
      end
      n_checks++;
    end
    if (writes != 1) begin
      n_fail++; $display("FAIL dup_count: got %0d writes want 1", writes);
    end
    n_checks++;
`ifdef BTB_ARB_STATS_EN
    if (stat_alloc !== 16'(drops_before)) begin
      n_fail++; $display("FAIL dup_stats: got %0d want %0d", stat_alloc, drops_before);
    end
    n_checks++;
`endif
  endtask

  task automatic test_inv();
    bus.STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_alloc(9'(9'h1F0 + i), 21'(i), 32'(i));
      step();
    end
    bus.alloc_valid_IN = 1'b0;
    bus.inv_req_IN = 1'b1;
    step();
    bus.inv_req_IN = 1'b0;
    bus.STALL = 1'b0;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) step();
      if (bus.wr_kind_OUT !== 2'b11 || bus.wr_index_OUT !== 9'(i) || bus.busy_OUT !== 1'b1) begin
        n_fail++; $display("FAIL inv_sweep[%0d]: got %h want kind11 idx %0d", i, obs, i);
      end
      n_checks++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs !== 68'h0) begin
        n_fail++; $display("FAIL inv_flushed[%0d]: got %h want 0", i, obs);
      end
      n_checks++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    bus.inv_req_IN = 1'b1;
    step();
    bus.inv_req_IN = 1'b0;
    for (int k = 0; k < 50; k++) step();
    bus.inv_req_IN = 1'b1;  // restart while index 50 is showing
    step();
    bus.inv_req_IN = 1'b0;
    if (bus.wr_kind_OUT !== 2'b11 || bus.wr_index_OUT !== 9'h0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL inv_restart: got %h want %h", obs, exp_vec());
    end
    n_checks++;
    for (int k = 0; k < 200; k++) step();
    if (bus.wr_index_OUT !== 9'd200) begin
      n_fail++; $display("FAIL pre_reset_idx: got %0d want 200", bus.wr_index_OUT);
    end
    n_checks++;
    RESET = 1'b0;
    #1;
    if (obs !== RST_VEC || bus.alloc_ready_OUT !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got %h rdy %b want %h rdy 0", obs, bus.alloc_ready_OUT,
                         RST_VEC);
    end
    n_checks++;
    model_reset();
    repeat (2) @(negedge clk);
    RESET = 1'b1;
    wait_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      bus.STALL          = ($urandom_range(0, 3) == 0);
      bus.inv_req_IN     = ($urandom_range(0, 999) == 0);
      bus.alloc_valid_IN = ($urandom_range(0, 1) == 1);
      bus.alloc_index_IN = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 7));
      bus.alloc_tag_IN   = 21'($urandom_range(0, 3));
      bus.alloc_target_IN = $urandom;
      bus.touch_valid_IN = ($urandom_range(0, 4) < 2);
      bus.touch_index_IN = 9'($urandom);
      bus.touch_way_IN   = 1'($urandom);
      if (bus.alloc_ready_OUT !== exp_ready()) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.alloc_ready_OUT,
                           exp_ready());
      end
      n_checks++;
      step();
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL rand_out[%0d]: got %h want %h", c, obs, exp_vec());
      end
      n_checks++;
    end
    clear_inputs();
`ifdef BTB_ARB_STATS_EN
    if (stat_touch !== 16'(m_touch_drops) || stat_alloc !== 16'(m_alloc_drops)) begin
      n_fail++; $display("FAIL rand_stats: got %0d/%0d want %0d/%0d", stat_touch, stat_alloc,
                         m_touch_drops, m_alloc_drops);
    end
    n_checks++;
`endif
  endtask

  initial begin
    RESET = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_sweep();
    test_bypass();
    test_stall_fill();
    test_touch();
    test_dup();
    test_inv();
    test_reset_mid_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
